// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD access arbiter: phase encoding,
// default bus timing (in clk cycles at 50 MHz) and the long-wait command check.
package lcd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StWait
  } lcd_state_e;

  localparam int unsigned DefTSetup     = 2;
  localparam int unsigned DefTEnHigh    = 25;
  localparam int unsigned DefTHold      = 2;
  localparam int unsigned DefTWaitChar  = 2500;
  localparam int unsigned DefTWaitClear = 82000;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Clear (0x01) and home (0x02/0x03) commands need the long execution wait.
  function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
    logic [7:0] slow_bits;
    slow_bits = LCD_CMD_CLEAR | LCD_CMD_HOME;
    return !rs && ((data & ~slow_bits) == 8'h00) && ((data & slow_bits) != 8'h00);
  endfunction

  function automatic int unsigned max_of5(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d,
                                          input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter2.sv
// Two-way round-robin arbiter. Grants are combinational; the last winner is
// remembered so a tie goes to the other requester next time.
module lcd_rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic grant_en,
  output logic gnt0,
  output logic gnt1
);

  // 1 means requester 1 won most recently; resets to 1 so requester 0 wins the first tie.
  logic last_grant_q;

  assign gnt0 = req0 & (~req1 | last_grant_q);
  assign gnt1 = req1 & (~req0 | ~last_grant_q);

  // Record the winner whenever a grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (grant_en && (gnt0 || gnt1)) begin
      last_grant_q <= gnt1;
    end
  end

endmodule

// File: rtl/lcd_access_arbiter.sv
// Shares one character-LCD port between two requesters: round-robin grant,
// then setup / enable pulse / hold / execution wait driven by one down-counter.
module lcd_access_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP      = DefTSetup,
  parameter int unsigned T_EN_HIGH    = DefTEnHigh,
  parameter int unsigned T_HOLD       = DefTHold,
  parameter int unsigned T_WAIT_CHAR  = DefTWaitChar,
  parameter int unsigned T_WAIT_CLEAR = DefTWaitClear
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       busy,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_on,
  output logic [7:0] lcd_data
);

  localparam int unsigned TMax = max_of5(T_SETUP, T_EN_HIGH, T_HOLD, T_WAIT_CHAR, T_WAIT_CLEAR);
  localparam int unsigned CntW = $clog2(TMax) + 1;

  // Each phase loads T-1 and moves on when the counter reaches zero.
  localparam logic [CntW-1:0] SetupLd = CntW'(T_SETUP - 1);
  localparam logic [CntW-1:0] PulseLd = CntW'(T_EN_HIGH - 1);
  localparam logic [CntW-1:0] HoldLd  = CntW'(T_HOLD - 1);
  localparam logic [CntW-1:0] CharLd  = CntW'(T_WAIT_CHAR - 1);
  localparam logic [CntW-1:0] ClearLd = CntW'(T_WAIT_CLEAR - 1);

  lcd_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q;
  logic            en_q;
  logic            rs_q;
  logic            on_q;
  logic            ack0_q;
  logic            ack1_q;
  logic [7:0]      data_q;

  logic grant_en;
  logic gnt0;
  logic gnt1;
  logic cnt_done;

  assign grant_en = (state_q == StIdle);
  assign cnt_done = (cnt_q == '0);

  lcd_rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .grant_en (grant_en),
    .gnt0     (gnt0),
    .gnt1     (gnt1)
  );

  // Transfer sequencer: all outputs are registered here; reset drops lcd_en at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      on_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      on_q   <= 1'b1;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gnt0 || gnt1) begin
            state_q <= StSetup;
            cnt_q   <= SetupLd;
            busy_q  <= 1'b1;
            ack0_q  <= gnt0;
            ack1_q  <= gnt1;
            rs_q    <= gnt1 ? rs1 : rs0;
            data_q  <= gnt1 ? data1 : data0;
          end
        end
        StSetup: begin
          if (cnt_done) begin
            state_q <= StPulse;
            cnt_q   <= PulseLd;
            en_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StPulse: begin
          if (cnt_done) begin
            state_q <= StHold;
            cnt_q   <= HoldLd;
            en_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold: begin
          if (cnt_done) begin
            state_q <= StWait;
            cnt_q   <= needs_long_wait(rs_q, data_q) ? ClearLd : CharLd;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWait: begin
          if (cnt_done) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign busy     = busy_q;
  assign lcd_en   = en_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_on   = on_q;
  assign lcd_data = data_q;

endmodule
